// File: rtl/clock_hms.sv
// clock_hms: BCD hours/minutes/seconds clock driven by a 4 MHz system clock.
// The run/set switch, increment button and field select are debounced on a slow
// strobe; in set mode each button press bumps one field without carrying.
// Optional feature macro: CLOCK_HMS_ALARM_EN adds an hour:minute alarm comparator.
module clock_hms #(
    parameter int DIV      = 4000000,
    parameter int DEB_BITS = 16,
    parameter bit MODE12   = 1'b0
) (
    input  logic       clk4m,
    input  logic       clr,
`ifdef CLOCK_HMS_ALARM_EN
    input  logic       alm_sel,
    input  logic       alm_en,
    output logic       alarm,
`endif
    input  logic       run_sw,
    input  logic [1:0] set_sel,
    input  logic       inc_btn,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic       pm,
    output logic       tick
);
    localparam int            PW     = $clog2(DIV);
    localparam logic [PW-1:0] LAST   = PW'(DIV - 1);
    localparam logic [7:0]    HR_RST = MODE12 ? 8'h12 : 8'h00;

    // Control bits: [1:0] set_sel, [2] inc_btn, [3] run_sw, [4] alm_sel (alarm build).
    // The reset pattern leaves the clock running, the button released and no field selected.
`ifdef CLOCK_HMS_ALARM_EN
    localparam int            NC      = 5;
    localparam logic [NC-1:0] CTL_RST = 5'b01011;
`else
    localparam int            NC      = 4;
    localparam logic [NC-1:0] CTL_RST = 4'b1011;
`endif

    logic [NC-1:0]       raw_ctl;
    logic [NC-1:0]       meta_ctl;
    logic [NC-1:0]       sync_ctl;
    logic [NC-1:0]       samp_ctl;
    logic [NC-1:0]       deb_ctl;
    logic [DEB_BITS-1:0] deb_cnt;
    logic                strobe;
    logic                run_deb;
    logic                inc_deb;
    logic [1:0]          sel_deb;
    logic                inc_prev;
    logic                inc_pulse;
    logic                edit_time;
    logic [PW-1:0]       pre_cnt;

`ifdef CLOCK_HMS_ALARM_EN
    logic       alm_sel_deb;
    logic [7:0] alm_hr;
    logic [7:0] alm_min;

    assign raw_ctl     = {alm_sel, run_sw, inc_btn, set_sel};
    assign alm_sel_deb = deb_ctl[4];
    assign edit_time   = ~alm_sel_deb;
`else
    assign raw_ctl   = {run_sw, inc_btn, set_sel};
    assign edit_time = 1'b1;
`endif

    assign strobe    = &deb_cnt;
    assign run_deb   = deb_ctl[3];
    assign inc_deb   = deb_ctl[2];
    assign sel_deb   = deb_ctl[1:0];
    assign inc_pulse = inc_deb & ~inc_prev;

    // Increment a two-digit BCD value, rolling the ones digit into the tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next value of a 00..59 field.
    function automatic logic [7:0] next_60(input logic [7:0] v);
        return (v == 8'h59) ? 8'h00 : bcd_inc(v);
    endfunction

    // Next hour: 00..23 in 24 h format, 12,01..11 in 12 h format.
    function automatic logic [7:0] next_hr(input logic [7:0] v);
        if (MODE12)
            return (v == 8'h12) ? 8'h01 : bcd_inc(v);
        else
            return (v == 8'h23) ? 8'h00 : bcd_inc(v);
    endfunction

    // Two-flop synchroniser so the raw switches never reach the debouncer asynchronously.
    always_ff @(posedge clk4m or posedge clr) begin
        if (clr) begin
            meta_ctl <= CTL_RST;
            sync_ctl <= CTL_RST;
        end else begin
            meta_ctl <= raw_ctl;
            sync_ctl <= meta_ctl;
        end
    end

    // Free-running counter whose all-ones state is the debounce sampling strobe.
    always_ff @(posedge clk4m or posedge clr) begin
        if (clr)
            deb_cnt <= '0;
        else
            deb_cnt <= deb_cnt + 1'b1;
    end

    // On each strobe a control bit follows its input only when two samples in a row agree.
    always_ff @(posedge clk4m or posedge clr) begin
        if (clr) begin
            samp_ctl <= CTL_RST;
            deb_ctl  <= CTL_RST;
        end else if (strobe) begin
            samp_ctl <= sync_ctl;
            deb_ctl  <= (sync_ctl & ~(sync_ctl ^ samp_ctl)) | (deb_ctl & (sync_ctl ^ samp_ctl));
        end
    end

    // Remember the previous debounced button level to form a single-cycle press pulse.
    always_ff @(posedge clk4m or posedge clr) begin
        if (clr)
            inc_prev <= 1'b0;
        else
            inc_prev <= inc_deb;
    end

    // Prescaler, timekeeping with full carry chain in run mode, field editing in set mode.
    always_ff @(posedge clk4m or posedge clr) begin
        if (clr) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
            sec_bcd <= 8'h00;
            min_bcd <= 8'h00;
            hr_bcd  <= HR_RST;
            pm      <= 1'b0;
        end else if (run_deb) begin
            if (pre_cnt == LAST) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
                sec_bcd <= next_60(sec_bcd);
                if (sec_bcd == 8'h59) begin
                    min_bcd <= next_60(min_bcd);
                    if (min_bcd == 8'h59) begin
                        hr_bcd <= next_hr(hr_bcd);
                        if (MODE12 && hr_bcd == 8'h11)
                            pm <= ~pm;
                    end
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                tick    <= 1'b0;
            end
        end else begin
            pre_cnt <= '0;
            tick    <= 1'b0;
            if (inc_pulse && edit_time) begin
                case (sel_deb)
                    2'b00:   sec_bcd <= next_60(sec_bcd);
                    2'b01:   min_bcd <= next_60(min_bcd);
                    2'b10:   hr_bcd  <= next_hr(hr_bcd);
                    default: begin end
                endcase
            end
        end
    end

`ifdef CLOCK_HMS_ALARM_EN
    // Alarm setpoint editing in set mode, and the registered hour:minute match flag.
    // The alarm setpoint has no PM bit, so in 12 h format it only matches AM times.
    always_ff @(posedge clk4m or posedge clr) begin
        if (clr) begin
            alm_hr  <= HR_RST;
            alm_min <= 8'h00;
            alarm   <= 1'b0;
        end else begin
            if (!run_deb && inc_pulse && alm_sel_deb) begin
                case (sel_deb)
                    2'b01:   alm_min <= next_60(alm_min);
                    2'b10:   alm_hr  <= next_hr(alm_hr);
                    default: begin end
                endcase
            end
            alarm <= alm_en && run_deb && (hr_bcd == alm_hr) && (min_bcd == alm_min) && !pm;
        end
    end
`endif

endmodule

// File: tb/tb_clock_hms.sv
// tb_clock_hms: directed bench for clock_hms with a 24 h and a 12 h instance
// sharing all inputs. An integer time model per instance advances on each
// observed tick and on each completed press; expected values are queued and
// popped at every comparison point.
module tb_clock_hms;
    localparam int DIV = 4;
    localparam int DEB = 2;

    logic       clk4m = 1'b0;
    logic       clr;
    logic       run_sw;
    logic       inc_btn;
    logic [1:0] set_sel;
    logic [7:0] sec_a, min_a, hr_a, sec_b, min_b, hr_b;
    logic       pm_a, pm_b, tick_a, tick_b;
`ifdef CLOCK_HMS_ALARM_EN
    logic       alm_sel, alm_en, alarm_a, alarm_b;
`endif

    int s24, m24, h24, s12, m12, h12;
    bit pm12;
    int sel_model;
    bit alm_target;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk4m = ~clk4m;

    clock_hms #(.DIV(DIV), .DEB_BITS(DEB), .MODE12(1'b0)) dut24 (
        .clk4m(clk4m), .clr(clr),
`ifdef CLOCK_HMS_ALARM_EN
        .alm_sel(alm_sel), .alm_en(alm_en), .alarm(alarm_a),
`endif
        .run_sw(run_sw), .set_sel(set_sel), .inc_btn(inc_btn),
        .sec_bcd(sec_a), .min_bcd(min_a), .hr_bcd(hr_a), .pm(pm_a), .tick(tick_a)
    );

    clock_hms #(.DIV(DIV), .DEB_BITS(DEB), .MODE12(1'b1)) dut12 (
        .clk4m(clk4m), .clr(clr),
`ifdef CLOCK_HMS_ALARM_EN
        .alm_sel(alm_sel), .alm_en(alm_en), .alarm(alarm_b),
`endif
        .run_sw(run_sw), .set_sel(set_sel), .inc_btn(inc_btn),
        .sec_bcd(sec_b), .min_bcd(min_b), .hr_bcd(hr_b), .pm(pm_b), .tick(tick_b)
    );

    task automatic model_reset();
        s24 = 0; m24 = 0; h24 = 0;
        s12 = 0; m12 = 0; h12 = 12; pm12 = 1'b0;
    endtask

    task automatic advance24();
        s24++;
        if (s24 == 60) begin
            s24 = 0;
            m24++;
            if (m24 == 60) begin
                m24 = 0;
                h24 = (h24 + 1) % 24;
            end
        end
    endtask

    task automatic advance12();
        s12++;
        if (s12 == 60) begin
            s12 = 0;
            m12++;
            if (m12 == 60) begin
                m12 = 0;
                if (h12 == 11) begin
                    h12 = 12;
                    pm12 = ~pm12;
                end else if (h12 == 12) begin
                    h12 = 1;
                end else begin
                    h12++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk4m);
        if (tick_a === 1'b1) advance24();
        if (tick_b === 1'b1) advance12();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic logic [31:0] bcd(input int x);
        logic [7:0] r;
        r[7:4] = 4'(x / 10);
        r[3:0] = 4'(x % 10);
        return {24'h0, r};
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_output(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic check_time(input string step);
        push_exp({step, " sec24"}, bcd(s24));
        push_exp({step, " min24"}, bcd(m24));
        push_exp({step, " hr24"},  bcd(h24));
        push_exp({step, " pm24"},  32'd0);
        push_exp({step, " sec12"}, bcd(s12));
        push_exp({step, " min12"}, bcd(m12));
        push_exp({step, " hr12"},  bcd(h12));
        push_exp({step, " pm12"},  {31'h0, pm12});
        check_output({24'h0, sec_a});
        check_output({24'h0, min_a});
        check_output({24'h0, hr_a});
        check_output({31'h0, pm_a});
        check_output({24'h0, sec_b});
        check_output({24'h0, min_b});
        check_output({24'h0, hr_b});
        check_output({31'h0, pm_b});
    endtask

    task automatic check_tick(input string step, input logic v);
        push_exp({step, " tick24"}, {31'h0, v});
        push_exp({step, " tick12"}, {31'h0, v});
        check_output({31'h0, tick_a});
        check_output({31'h0, tick_b});
    endtask

    // After clr falls just past a falling edge, tick must appear on the DIV-th rising edge.
    task automatic check_first_tick(input string step);
        for (int i = 0; i < DIV - 1; i++) begin
            cyc();
            check_tick({step, " quiet"}, 1'b0);
        end
        cyc();
        check_tick({step, " due"}, 1'b1);
    endtask

    task automatic wait_tick(input string step);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            if (tick_a === 1'b1) seen = 1'b1;
        end
        push_exp({step, " tick_seen"}, 32'd1);
        check_output({31'h0, seen});
    endtask

    task automatic model_inc();
        if (!alm_target) begin
            case (sel_model)
                0: begin s24 = (s24 + 1) % 60; s12 = (s12 + 1) % 60; end
                1: begin m24 = (m24 + 1) % 60; m12 = (m12 + 1) % 60; end
                2: begin
                    h24 = (h24 + 1) % 24;
                    h12 = (h12 == 12) ? 1 : h12 + 1;
                end
                default: begin end
            endcase
        end
    endtask

    task automatic apply_press(input int hold, input bit bounce);
        if (bounce) begin
            inc_btn = 1'b1; cyc();
            inc_btn = 1'b0; cyc();
        end
        inc_btn = 1'b1;
        cycles(hold);
        inc_btn = 1'b0;
        cycles(20);
        model_inc();
    endtask

    task automatic select_field(input int sel);
        set_sel = 2'(sel);
        sel_model = sel;
        cycles(20);
    endtask

    task automatic press_to(input int target);
        int cur, range, n;
        cur   = (sel_model == 0) ? s24 : (sel_model == 1) ? m24 : h24;
        range = (sel_model == 2) ? 24 : 60;
        n     = (target - cur + range) % range;
        for (int i = 0; i < n; i++) apply_press(20, 1'b0);
    endtask

    task automatic enter_set();
        run_sw = 1'b0;
        cycles(30);
    endtask

    initial begin
        clr = 1'b1; run_sw = 1'b1; inc_btn = 1'b0; set_sel = 2'b11;
        sel_model = 3; alm_target = 1'b0;
`ifdef CLOCK_HMS_ALARM_EN
        alm_sel = 1'b0; alm_en = 1'b0;
`endif
        model_reset();
        cycles(3);
        check_time("reset");
        check_tick("reset", 1'b0);

        #1 clr = 1'b0;
        check_first_tick("release");
        check_time("first_second");

        enter_set();
        begin
            int nt;
            nt = 0;
            for (int i = 0; i < 20; i++) begin
                cyc();
                if (tick_a === 1'b1 || tick_b === 1'b1) nt++;
            end
            push_exp("set_no_tick", 32'd0);
            check_output(32'(nt));
        end
        check_time("set_entry");

        select_field(0);
        apply_press(20, 1'b1);
        check_time("bounce_press");
        press_to(59);
        check_time("sec59");

        select_field(2);
        press_to(23);
        check_time("hr23");

        select_field(1);
        press_to(59);
        check_time("min59");
        apply_press(60, 1'b0);
        check_time("min_wrap");
        press_to(59);
        check_time("min59_again");

        select_field(3);
        apply_press(20, 1'b0);
        check_time("sel_none");

        run_sw = 1'b1;
        wait_tick("midnight");
        check_time("midnight");
        check_first_tick("steady");
        check_time("midnight_plus1");

        enter_set();
        select_field(1);
        press_to(59);
        select_field(0);
        press_to(59);
        check_time("pm_preset");
        run_sw = 1'b1;
        wait_tick("one_pm");
        check_time("one_pm");

        cyc();
        cyc();
        #1 clr = 1'b1;
        model_reset();
        #1;
        check_time("mid_clr");
        check_tick("mid_clr", 1'b0);
        cycles(2);
        #1 clr = 1'b0;
        check_first_tick("clr_release");
        check_time("clr_release");

`ifdef CLOCK_HMS_ALARM_EN
        enter_set();
        alm_sel = 1'b1; alm_target = 1'b1;
        cycles(20);
        select_field(1);
        for (int i = 0; i < 30; i++) apply_press(20, 1'b0);
        select_field(2);
        for (int i = 0; i < 7; i++) apply_press(20, 1'b0);
        alm_sel = 1'b0; alm_target = 1'b0;
        cycles(20);
        press_to(7);
        select_field(1);
        press_to(29);
        select_field(0);
        press_to(59);
        check_time("alarm_preset");
        alm_en = 1'b1;
        run_sw = 1'b1;
        wait_tick("alarm_hit");
        cycles(2);
        push_exp("alarm_on", 32'd1);
        check_output({31'h0, alarm_a});
        for (int i = 0; i < 60; i++) wait_tick("alarm_minute");
        cycles(2);
        check_time("alarm_after");
        push_exp("alarm_off", 32'd0);
        check_output({31'h0, alarm_a});
        alm_en = 1'b0;
        cycles(2);
        push_exp("alarm_disabled", 32'd0);
        check_output({31'h0, alarm_a});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
